// File: rtl/cp0_timer_exc_unit.sv
// CP0 coprocessor for the single-issue MIPS core: Count/Compare timer, exception
// entry/ERET bookkeeping, masked interrupt request and an mtc0 forwarding window.
module cp0_timer_exc_unit #(
  parameter int          NUM_BYPASS = 4,
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] PRID_VAL   = 32'h004E4503
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall_hold,
  input  logic                     stall_flush,
  input  logic                     we,
  input  logic [4:0]               waddr,
  input  logic [2:0]               wsel,
  input  logic [31:0]              wdata,
  input  logic [4:0]               raddr,
  input  logic [2:0]               rsel,
  output logic [31:0]              rdata,
  input  logic [5:0]               hw_int,
  input  logic                     exc_valid,
  input  logic [4:0]               exc_code,
  input  logic [31:0]              exc_pc,
  input  logic                     exc_bd,
  input  logic [31:0]              exc_badvaddr,
  input  logic                     eret,
  input  logic [41*NUM_BYPASS-1:0] fwd_bus,
  output logic [31:0]              status_o,
  output logic [31:0]              cause_o,
  output logic [31:0]              epc_o,
  output logic                     int_req,
  output logic                     timer_int
);

  localparam logic [4:0]  REG_BADVADDR = 5'd8;
  localparam logic [4:0]  REG_COUNT    = 5'd9;
  localparam logic [4:0]  REG_COMPARE  = 5'd11;
  localparam logic [4:0]  REG_STATUS   = 5'd12;
  localparam logic [4:0]  REG_CAUSE    = 5'd13;
  localparam logic [4:0]  REG_EPC      = 5'd14;
  localparam logic [4:0]  REG_PRID     = 5'd15;
  localparam logic [4:0]  REG_CONFIG   = 5'd16;
  localparam logic [31:0] CONFIG0_VAL  = 32'h8000_0083;
  localparam logic [31:0] CONFIG1_VAL  = 32'h0108_8420;
  localparam logic [3:0]  DIV_MAX      = 4'(COUNT_DIV - 1);

  logic [7:0]  status_im;
  logic        status_exl;
  logic        status_ie;
  logic        cause_bd;
  logic        cause_ti;
  logic        cause_iv;
  logic [5:0]  cause_ip_hw;
  logic [1:0]  cause_ip_sw;
  logic [4:0]  cause_exc;
  logic [31:0] epc;
  logic [31:0] badvaddr;
  logic [31:0] count;
  logic [31:0] compare;
  logic [3:0]  div_cnt;
  logic [40:0] fwd_buf [NUM_BYPASS];

  logic wr_sel0;
  logic wr_count;
  logic wr_compare;
  logic wr_status;
  logic wr_cause;
  logic wr_epc;
  logic div_wrap;
  logic bad_addr_exc;

  assign wr_sel0      = we && (wsel == 3'd0);
  assign wr_count     = wr_sel0 && (waddr == REG_COUNT);
  assign wr_compare   = wr_sel0 && (waddr == REG_COMPARE);
  assign wr_status    = wr_sel0 && (waddr == REG_STATUS);
  assign wr_cause     = wr_sel0 && (waddr == REG_CAUSE);
  assign wr_epc       = wr_sel0 && (waddr == REG_EPC);
  assign div_wrap     = (div_cnt == DIV_MAX);
  assign bad_addr_exc = (exc_code == 5'd4) || (exc_code == 5'd5);

  assign status_o  = {3'b000, 1'b1, 12'b0, status_im, 6'b0, status_exl, status_ie};
  assign cause_o   = {cause_bd, cause_ti, 6'b0, cause_iv, 7'b0, cause_ip_hw, cause_ip_sw,
                      1'b0, cause_exc, 2'b00};
  assign epc_o     = epc;
  assign timer_int = cause_ti;
  assign int_req   = status_ie & ~status_exl & |({cause_ip_hw, cause_ip_sw} & status_im);

  // Architectural state. Exception beats ERET beats mtc0 on every field they share;
  // an exception taken with EXL already set leaves EPC/BD alone, so mtc0 may still write EPC.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_im   <= '0;
      status_exl  <= 1'b0;
      status_ie   <= 1'b0;
      cause_bd    <= 1'b0;
      cause_ti    <= 1'b0;
      cause_iv    <= 1'b0;
      cause_ip_hw <= '0;
      cause_ip_sw <= '0;
      cause_exc   <= '0;
      epc         <= '0;
      badvaddr    <= '0;
      count       <= '0;
      compare     <= '0;
      div_cnt     <= '0;
    end else begin
      div_cnt <= div_wrap ? 4'd0 : div_cnt + 4'd1;
      if (wr_count)
        count <= wdata;
      else if (div_wrap)
        count <= count + 32'd1;

      if (wr_compare) begin
        compare  <= wdata;
        cause_ti <= 1'b0;
      end else if ((count == compare) && (compare != 32'd0)) begin
        cause_ti <= 1'b1;
      end

      cause_ip_hw <= {hw_int[5] | cause_ti, hw_int[4:0]};

      if (wr_status) begin
        status_im <= wdata[15:8];
        status_ie <= wdata[0];
      end
      if (exc_valid)
        status_exl <= 1'b1;
      else if (eret)
        status_exl <= 1'b0;
      else if (wr_status)
        status_exl <= wdata[1];

      if (wr_cause) begin
        cause_ip_sw <= wdata[9:8];
        cause_iv    <= wdata[23];
      end

      if (exc_valid && !status_exl) begin
        epc      <= exc_bd ? exc_pc - 32'd4 : exc_pc;
        cause_bd <= exc_bd;
      end else if (wr_epc) begin
        epc <= wdata;
      end

      if (exc_valid) begin
        cause_exc <= exc_code;
        if (bad_addr_exc)
          badvaddr <= exc_badvaddr;
      end
    end
  end

  // Forwarding window: flush beats hold, otherwise the bus is captured every cycle.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_BYPASS; i++) begin
      if (rst || stall_flush)
        fwd_buf[i] <= '0;
      else if (!stall_hold)
        fwd_buf[i] <= fwd_bus[i*41 +: 41];
    end
  end

  // Read mux; the forwarding scan runs from the oldest channel down so channel 0 wins.
  always_comb begin
    rdata = 32'd0;
    if (rsel == 3'd0) begin
      case (raddr)
        REG_BADVADDR: rdata = badvaddr;
        REG_COUNT:    rdata = count;
        REG_COMPARE:  rdata = compare;
        REG_STATUS:   rdata = status_o;
        REG_CAUSE:    rdata = cause_o;
        REG_EPC:      rdata = epc;
        REG_PRID:     rdata = PRID_VAL;
        REG_CONFIG:   rdata = CONFIG0_VAL;
        default:      rdata = 32'd0;
      endcase
    end else if ((rsel == 3'd1) && (raddr == REG_CONFIG)) begin
      rdata = CONFIG1_VAL;
    end
    for (int i = NUM_BYPASS - 1; i >= 0; i--) begin
      if (fwd_buf[i][40] && (fwd_buf[i][39:35] == raddr) && (fwd_buf[i][34:32] == rsel))
        rdata = fwd_buf[i][31:0];
    end
  end

endmodule

// File: tb/tb_cp0_timer_exc_unit.sv
// Directed scenarios plus randomized traffic for cp0_timer_exc_unit, checked against
// a field-mask reference model of the CP0 register file.
module tb_cp0_timer_exc_unit;

  localparam int          NB   = 4;
  localparam int          DIV  = 2;
  localparam logic [31:0] PRID = 32'h004E4503;
  localparam logic [31:0] ST_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CA_WMASK = 32'h0080_0300;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall_hold, stall_flush, we, exc_valid, exc_bd, eret;
  logic [4:0]    waddr, raddr, exc_code;
  logic [2:0]    wsel, rsel;
  logic [31:0]   wdata, rdata, exc_pc, exc_badvaddr;
  logic [5:0]    hw_int;
  logic [41*NB-1:0] fwd_bus;
  logic [31:0]   status_o, cause_o, epc_o;
  logic          int_req, timer_int;

  int n_vec  = 0;
  int n_miss = 0;

  logic [31:0] m_status, m_cause, m_epc, m_badv, m_count, m_compare;
  int unsigned m_cycles;
  logic [40:0] m_fwd [NB];

  cp0_timer_exc_unit #(.NUM_BYPASS(NB), .COUNT_DIV(DIV), .PRID_VAL(PRID)) dut (
    .clk(clk), .rst(rst), .stall_hold(stall_hold), .stall_flush(stall_flush),
    .we(we), .waddr(waddr), .wsel(wsel), .wdata(wdata),
    .raddr(raddr), .rsel(rsel), .rdata(rdata), .hw_int(hw_int),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
    .exc_badvaddr(exc_badvaddr), .eret(eret), .fwd_bus(fwd_bus),
    .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o),
    .int_req(int_req), .timer_int(timer_int)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit wr(input logic [4:0] a);
    return we && (wsel == 3'd0) && (waddr == a);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a, input logic [2:0] s);
    for (int i = 0; i < NB; i++)
      if (m_fwd[i][40] && m_fwd[i][39:35] == a && m_fwd[i][34:32] == s) return m_fwd[i][31:0];
    if (s == 3'd0) begin
      case (a)
        5'd8:  return m_badv;
        5'd9:  return m_count;
        5'd11: return m_compare;
        5'd12: return m_status;
        5'd13: return m_cause;
        5'd14: return m_epc;
        5'd15: return PRID;
        5'd16: return 32'h8000_0083;
        default: return 32'd0;
      endcase
    end
    if (s == 3'd1 && a == 5'd16) return 32'h0108_8420;
    return 32'd0;
  endfunction

  task automatic model_reset();
    m_status = 32'h1000_0000;
    m_cause = 0; m_epc = 0; m_badv = 0; m_count = 0; m_compare = 0;
    m_cycles = 0;
    for (int i = 0; i < NB; i++) m_fwd[i] = '0;
  endtask

  // Next state from the register-level rules, using the inputs present this cycle.
  task automatic model_step();
    logic [31:0] old_st, old_ca, old_cnt;
    logic ti;
    if (rst) begin
      model_reset();
      return;
    end
    old_st = m_status; old_ca = m_cause; old_cnt = m_count;
    m_cycles++;
    if (wr(5'd9)) m_count = wdata;
    else if (m_cycles % DIV == 0) m_count = m_count + 1;
    ti = old_ca[30];
    if (wr(5'd11)) ti = 1'b0;
    else if (old_cnt == m_compare && m_compare != 0) ti = 1'b1;
    if (wr(5'd11)) m_compare = wdata;
    m_cause[30] = ti;
    m_cause[15:10] = {hw_int[5] | old_ca[30], hw_int[4:0]};
    if (wr(5'd13)) m_cause = (m_cause & ~CA_WMASK) | (wdata & CA_WMASK);
    if (wr(5'd12)) m_status = (old_st & ~ST_WMASK) | (wdata & ST_WMASK);
    if (wr(5'd14)) m_epc = wdata;
    if (eret) m_status[1] = 1'b0;
    if (exc_valid) begin
      m_status[1] = 1'b1;
      m_cause[6:2] = exc_code;
      if (!old_st[1]) begin
        m_epc = exc_pc - (exc_bd ? 32'd4 : 32'd0);
        m_cause[31] = exc_bd;
      end
      if (exc_code == 5'd4 || exc_code == 5'd5) m_badv = exc_badvaddr;
    end
    for (int i = 0; i < NB; i++) begin
      if (stall_flush) m_fwd[i] = '0;
      else if (!stall_hold) m_fwd[i] = fwd_bus[i*41 +: 41];
    end
  endtask

  // One clock: compare everything against the model mid-cycle, then advance both.
  task automatic applyStimulus();
    logic exp_int;
    @(negedge clk);
    exp_int = m_status[0] & ~m_status[1] & |(m_cause[15:8] & m_status[15:8]);
    checkOutput("rdata", rdata, m_read(raddr, rsel));
    checkOutput("status", status_o, m_status);
    checkOutput("cause", cause_o, m_cause);
    checkOutput("epc", epc_o, m_epc);
    checkOutput("int_req", {31'd0, int_req}, {31'd0, exp_int});
    checkOutput("timer_int", {31'd0, timer_int}, {31'd0, m_cause[30]});
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall_hold = 0; stall_flush = 0; we = 0; waddr = 0; wsel = 0; wdata = 0;
    raddr = 5'd12; rsel = 0; hw_int = 0; exc_valid = 0; exc_code = 0; exc_pc = 0;
    exc_bd = 0; exc_badvaddr = 0; eret = 0; fwd_bus = '0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we = 1; waddr = a; wsel = 0; wdata = d;
    applyStimulus();
    we = 0;
  endtask

  task automatic read_check(input string tag, input logic [4:0] a, input logic [2:0] s,
                            input logic [31:0] exp);
    raddr = a; rsel = s;
    #1;
    checkOutput(tag, rdata, exp);
  endtask

  function automatic logic [40:0] fwd_entry(input logic [4:0] a, input logic [31:0] d);
    return {1'b1, a, 3'd0, d};
  endfunction

  initial begin
    logic hit;
    logic [4:0] regs [10];
    logic [4:0] codes [8];
    regs  = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd0, 5'd31};
    codes = '{5'd0, 5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd12, 5'd13};

    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 0;

    read_check("reset_status", 5'd12, 3'd0, 32'h1000_0000);
    read_check("reset_prid", 5'd15, 3'd0, PRID);
    read_check("reset_config1", 5'd16, 3'd1, 32'h0108_8420);

    // Count divider and wrap
    repeat (10) applyStimulus();
    read_check("count_after10", 5'd9, 3'd0, 32'd5);
    mtc0(5'd9, 32'hFFFF_FFFF);
    repeat (2) applyStimulus();
    read_check("count_wrap", 5'd9, 3'd0, 32'd0);

    // Timer match, interrupt request and clear via Compare
    mtc0(5'd11, 32'd8);
    hit = 0;
    for (int k = 0; k < 64 && !hit; k++) begin
      read_check("count_poll", 5'd9, 3'd0, m_count);
      if (rdata == 32'd8) hit = 1;
      else applyStimulus();
    end
    checkOutput("count_reach8", {31'd0, hit}, 32'd1);
    checkOutput("ti_before", {31'd0, timer_int}, 32'd0);
    applyStimulus();
    checkOutput("ti_set", {31'd0, timer_int}, 32'd1);
    applyStimulus();
    checkOutput("cause_ip7", {31'd0, cause_o[15]}, 32'd1);
    mtc0(5'd12, 32'h0000_8001);
    checkOutput("int_req_on", {31'd0, int_req}, 32'd1);
    mtc0(5'd11, 32'd20);
    checkOutput("ti_clear", {31'd0, timer_int}, 32'd0);

    // Exceptions
    exc_valid = 1; exc_code = 5'd4; exc_pc = 32'hBFC0_0100; exc_bd = 1; exc_badvaddr = 32'h1235;
    applyStimulus();
    exc_valid = 0;
    checkOutput("exc_epc", epc_o, 32'hBFC0_00FC);
    checkOutput("exc_bd", {31'd0, cause_o[31]}, 32'd1);
    checkOutput("exc_code4", {27'd0, cause_o[6:2]}, 32'd4);
    checkOutput("exc_exl", {31'd0, status_o[1]}, 32'd1);
    read_check("exc_badvaddr", 5'd8, 3'd0, 32'h1235);
    exc_valid = 1; exc_code = 5'd8; exc_pc = 32'h200; exc_bd = 0; exc_badvaddr = 32'h9999;
    applyStimulus();
    exc_valid = 0;
    checkOutput("exc2_epc", epc_o, 32'hBFC0_00FC);
    checkOutput("exc2_code", {27'd0, cause_o[6:2]}, 32'd8);
    read_check("exc2_badvaddr", 5'd8, 3'd0, 32'h1235);

    // ERET against a simultaneous exception, then alone
    exc_valid = 1; exc_code = 5'd10; eret = 1;
    applyStimulus();
    exc_valid = 0;
    checkOutput("eret_exc_exl", {31'd0, status_o[1]}, 32'd1);
    checkOutput("eret_exc_code", {27'd0, cause_o[6:2]}, 32'd10);
    applyStimulus();
    eret = 0;
    checkOutput("eret_exl", {31'd0, status_o[1]}, 32'd0);

    // Forwarding window
    fwd_bus = '0;
    fwd_bus[0*41 +: 41] = fwd_entry(5'd12, 32'hAAAA);
    fwd_bus[2*41 +: 41] = fwd_entry(5'd12, 32'hBBBB);
    applyStimulus();
    read_check("fwd_ch0_wins", 5'd12, 3'd0, 32'hAAAA);
    stall_flush = 1; stall_hold = 1;
    applyStimulus();
    stall_flush = 0; stall_hold = 0;
    read_check("fwd_flushed", 5'd12, 3'd0, 32'h1000_8001);
    applyStimulus();
    stall_hold = 1;
    fwd_bus[0*41 +: 41] = fwd_entry(5'd12, 32'hCCCC);
    applyStimulus();
    read_check("fwd_hold", 5'd12, 3'd0, 32'hAAAA);
    stall_hold = 0; fwd_bus = '0;
    applyStimulus();

    // Write masks and read-only registers
    mtc0(5'd12, 32'hFFFF_FFFF);
    checkOutput("status_mask", status_o, 32'h1000_FF03);
    mtc0(5'd15, 32'h1234_5678);
    read_check("prid_ro", 5'd15, 3'd0, PRID);
    mtc0(5'd12, 32'h0000_0000);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      idle_inputs();
      hw_int = 6'($urandom_range(0, 63)) & ($urandom_range(0, 3) == 0 ? 6'h3F : 6'h00);
      if ($urandom_range(0, 2) == 0) begin
        we = 1;
        waddr = regs[$urandom_range(0, 7)];
        wsel = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
        wdata = $urandom;
        if (waddr == 5'd11) wdata = m_count + 32'($urandom_range(0, 6));
      end
      exc_valid = ($urandom_range(0, 9) == 0);
      exc_code = codes[$urandom_range(0, 7)];
      exc_pc = $urandom; exc_bd = 1'($urandom_range(0, 1)); exc_badvaddr = $urandom;
      eret = ($urandom_range(0, 7) == 0);
      stall_flush = ($urandom_range(0, 15) == 0);
      stall_hold = ($urandom_range(0, 5) == 0);
      for (int c = 0; c < NB; c++)
        if ($urandom_range(0, 1) == 1)
          fwd_bus[c*41 +: 41] = {1'b1, regs[$urandom_range(0, 9)], 3'($urandom_range(0, 1)),
                                 32'($urandom)};
      raddr = regs[$urandom_range(0, 9)];
      rsel = ($urandom_range(0, 5) == 0) ? 3'd1 : 3'd0;
      applyStimulus();
    end

    // Mid-run reset
    idle_inputs();
    mtc0(5'd14, 32'hDEAD_BEEF);
    rst = 1;
    applyStimulus();
    rst = 0;
    checkOutput("rst_status", status_o, 32'h1000_0000);
    checkOutput("rst_cause", cause_o, 32'd0);
    checkOutput("rst_epc", epc_o, 32'd0);
    read_check("rst_count", 5'd9, 3'd0, 32'd0);
    read_check("rst_compare", 5'd11, 3'd0, 32'd0);
    read_check("rst_config0", 5'd16, 3'd0, 32'h8000_0083);
    repeat (3) applyStimulus();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
